// File: rtl/tt_sweep_pkg.sv
// Shared constants and types for the truth-table sweep stage: default
// netlist size, the deepest supported netlist latency, FSM state names and
// the minterm index type.
package tt_sweep_pkg;

    // Default number of netlist inputs and the matching truth-table width.
    localparam int NIN_DEF = 4;
    localparam int TTW_DEF = 1 << NIN_DEF;

    // Deepest netlist pipeline the sweep can wait out.
    localparam int LAT_MAX = 4;

    // Width of the drain counter; it has to hold LAT_MAX - 1.
    localparam int DRW = $clog2(LAT_MAX + 1);

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Index of one minterm of the default-size netlist.
    typedef logic [NIN_DEF-1:0] minterm_t;

endpackage : tt_sweep_pkg

// File: rtl/tt_lat_pipe.sv
// Valid + minterm-tag delay line matching the latency of the netlist under
// test. A tag entering at cycle c leaves at cycle c + DEPTH, which is exactly
// when the netlist output for that minterm is valid. DEPTH = 0 is a plain
// wire for purely combinational netlists.
module tt_lat_pipe
    import tt_sweep_pkg::*;
#(
    parameter int W     = NIN_DEF,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] tag_i,
    output logic         valid_o,
    output logic [W-1:0] tag_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset are not needed without stages.
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ rst_n;

            assign valid_o = valid_i;
            assign tag_o   = tag_i;
        end else begin : g_pipe
            logic [DEPTH-1:0]        vld_q;
            logic [DEPTH-1:0]        vld_d;
            logic [DEPTH-1:0][W-1:0] tag_q;
            logic [DEPTH-1:0][W-1:0] tag_d;

            // Next stage contents: shift by one; empty slots carry a zero tag.
            always_comb begin
                vld_d    = {DEPTH{1'b0}};
                tag_d    = {(DEPTH * W){1'b0}};
                vld_d[0] = valid_i;
                tag_d[0] = valid_i ? tag_i : {W{1'b0}};
                for (int i = 1; i < DEPTH; i++) begin
                    vld_d[i] = vld_q[i-1];
                    tag_d[i] = tag_q[i-1];
                end
            end

            // Stage registers; reset flushes any in-flight samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= {DEPTH{1'b0}};
                    tag_q <= {(DEPTH * W){1'b0}};
                end else begin
                    vld_q <= vld_d;
                    tag_q <= tag_d;
                end
            end

            assign valid_o = vld_q[DEPTH-1];
            assign tag_o   = tag_q[DEPTH-1];
        end
    endgenerate

endmodule : tt_lat_pipe

// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table sweep around a small single-output netlist.
// On an accepted start the block drives minterms 0..TTW-1 in ascending
// order, waits out the netlist latency, captures each output bit into its
// truth-table slot and compares it against the expected table latched at
// start. done_o pulses for one cycle once the last sample is in; the
// results then hold until the next accepted start.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter  int NIN = NIN_DEF,
    parameter  int LAT = 0,
    localparam int TTW = 1 << NIN
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [TTW-1:0] expect_tt_i,
    output logic [NIN-1:0] x_o,
    input  logic           y_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [TTW-1:0] tt_o,
    output logic           match_o,
    output logic [NIN:0]   err_cnt_o,
    output logic [NIN-1:0] first_err_o
);

    // State encodings shared with the package enum.
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SWEEP = SWEEP;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    localparam logic [NIN-1:0] X_ZERO   = {NIN{1'b0}};
    localparam logic [NIN-1:0] X_ONE    = {{(NIN-1){1'b0}}, 1'b1};
    localparam logic [NIN-1:0] X_LAST   = {NIN{1'b1}};
    localparam logic [NIN:0]   ERR_ZERO = {(NIN+1){1'b0}};
    localparam logic [NIN:0]   ERR_ONE  = {{NIN{1'b0}}, 1'b1};
    localparam logic [DRW-1:0] DR_ZERO  = {DRW{1'b0}};
    localparam logic [DRW-1:0] DR_ONE   = {{(DRW-1){1'b0}}, 1'b1};
    // Drain runs LAT cycles, counted down to zero.
    localparam logic [DRW-1:0] DR_INIT  = (LAT > 0) ? DRW'(LAT - 1) : {DRW{1'b0}};

    logic [1:0]     state_q;
    logic [1:0]     state_d;
    logic [NIN-1:0] x_q;
    logic [NIN-1:0] x_d;
    logic [DRW-1:0] dr_q;
    logic [DRW-1:0] dr_d;
    logic [TTW-1:0] exp_q;
    logic [TTW-1:0] exp_d;
    logic [TTW-1:0] tt_q;
    logic [TTW-1:0] tt_d;
    logic [NIN:0]   err_q;
    logic [NIN:0]   err_d;
    logic [NIN-1:0] first_q;
    logic [NIN-1:0] first_d;
    logic           match_q;
    logic           match_d;
    logic           busy_q;
    logic           busy_d;
    logic           done_q;
    logic           done_d;

    logic           start_acc_s;
    logic           tag_vld_s;
    logic           pipe_vld_s;
    logic [NIN-1:0] pipe_tag_s;
    logic           miss_s;

    // A start is only honoured while idle.
    assign start_acc_s = (state_q == S_IDLE) && start_i;

    // Each SWEEP cycle presents exactly one fresh minterm; drain cycles
    // repeat the last minterm and must not be captured again.
    assign tag_vld_s = (state_q == S_SWEEP);

    tt_lat_pipe #(
        .W     (NIN),
        .DEPTH (LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (tag_vld_s),
        .tag_i   (x_q),
        .valid_o (pipe_vld_s),
        .tag_o   (pipe_tag_s)
    );

    // The emerging sample disagrees with the expected bit for its minterm.
    assign miss_s = y_i ^ exp_q[pipe_tag_s];

    // Sequencer: state, driven minterm and drain countdown.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        dr_d    = dr_q;
        case (state_q)
            S_IDLE: begin
                x_d  = X_ZERO;
                dr_d = DR_ZERO;
                if (start_i) begin
                    state_d = S_SWEEP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SWEEP: begin
                if (x_q == X_LAST) begin
                    if (LAT > 0) begin
                        state_d = S_DRAIN;
                        x_d     = X_LAST;
                        dr_d    = DR_INIT;
                    end else begin
                        state_d = S_DONE;
                        x_d     = X_ZERO;
                    end
                end else begin
                    state_d = S_SWEEP;
                    x_d     = x_q + X_ONE;
                end
            end
            S_DRAIN: begin
                if (dr_q == DR_ZERO) begin
                    state_d = S_DONE;
                    x_d     = X_ZERO;
                end else begin
                    state_d = S_DRAIN;
                    dr_d    = dr_q - DR_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                x_d     = X_ZERO;
                dr_d    = DR_ZERO;
            end
            default: begin
                state_d = S_IDLE;
                x_d     = X_ZERO;
                dr_d    = DR_ZERO;
            end
        endcase
    end

    // Capture and compare: clear on start, otherwise fold in each emerging sample.
    always_comb begin
        exp_d   = exp_q;
        tt_d    = tt_q;
        err_d   = err_q;
        first_d = first_q;
        if (start_acc_s) begin
            exp_d   = expect_tt_i;
            tt_d    = {TTW{1'b0}};
            err_d   = ERR_ZERO;
            first_d = X_ZERO;
        end else if (pipe_vld_s) begin
            tt_d[pipe_tag_s] = y_i;
            if (miss_s) begin
                err_d = err_q + ERR_ONE;
                // Minterms arrive in ascending order, so the first miss is the lowest.
                if (err_q == ERR_ZERO) begin
                    first_d = pipe_tag_s;
                end else begin
                    first_d = first_q;
                end
            end else begin
                err_d = err_q;
            end
        end else begin
            tt_d = tt_q;
        end
    end

    // Status flags, derived from the next state so they are registered outputs.
    always_comb begin
        busy_d  = (state_d == S_SWEEP) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
        match_d = match_q;
        if (start_acc_s) begin
            match_d = 1'b0;
        end else if (state_d == S_DONE) begin
            // err_d already includes the final sample landing on this edge.
            match_d = (err_d == ERR_ZERO);
        end else begin
            match_d = match_q;
        end
    end

    // All state and outputs; reset abandons any sweep without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= X_ZERO;
            dr_q    <= DR_ZERO;
            exp_q   <= {TTW{1'b0}};
            tt_q    <= {TTW{1'b0}};
            err_q   <= ERR_ZERO;
            first_q <= X_ZERO;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            dr_q    <= dr_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            first_q <= first_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_o         = x_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tt_o        = tt_q;
    assign match_o     = match_q;
    assign err_cnt_o   = err_q;
    assign first_err_o = first_q;

endmodule : tt_sweep_capture

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture. Two instances: index 0 around a combinational
// netlist (LAT = 0), index 1 around a netlist with two register stages
// (LAT = 2). Each netlist is modelled as a 16-entry lookup table. Starting
// a sweep pushes the expected result (computed directly from the table and
// the expected table) into a per-instance queue; a monitor pops and compares
// whenever done_o is seen.
module tb_tt_sweep_capture;

    localparam int TTW = 16;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  err;
        logic [3:0]  first;
        logic        match;
        int unsigned cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [1:0]        start_v;
    logic [1:0][15:0]  expin_v;
    logic [1:0][15:0]  net_v;
    wire  [1:0][3:0]   x_v;
    wire  [1:0]        y_v;
    wire  [1:0]        busy_v;
    wire  [1:0]        done_v;
    wire  [1:0][15:0]  tt_v;
    wire  [1:0]        match_v;
    wire  [1:0][4:0]   err_v;
    wire  [1:0][3:0]   first_v;

    logic              s1_q;
    logic              y1_q;
    int unsigned       cyc;
    int                n_cmp;
    int                n_err;
    exp_t              q0[$];
    exp_t              q1[$];

    tt_sweep_capture #(.NIN(4), .LAT(0)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_v[0]),
        .expect_tt_i (expin_v[0]),
        .x_o         (x_v[0]),
        .y_i         (y_v[0]),
        .busy_o      (busy_v[0]),
        .done_o      (done_v[0]),
        .tt_o        (tt_v[0]),
        .match_o     (match_v[0]),
        .err_cnt_o   (err_v[0]),
        .first_err_o (first_v[0])
    );

    tt_sweep_capture #(.NIN(4), .LAT(2)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_v[1]),
        .expect_tt_i (expin_v[1]),
        .x_o         (x_v[1]),
        .y_i         (y_v[1]),
        .busy_o      (busy_v[1]),
        .done_o      (done_v[1]),
        .tt_o        (tt_v[1]),
        .match_o     (match_v[1]),
        .err_cnt_o   (err_v[1]),
        .first_err_o (first_v[1])
    );

    // Netlist models: combinational lookup, and lookup followed by two flops.
    assign y_v[0] = net_v[0][x_v[0]];
    assign y_v[1] = y1_q;

    always @(posedge clk) begin
        s1_q <= net_v[1][x_v[1]];
        y1_q <= s1_q;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a falling edge it equals the number of rising edges so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    // Reference result: captured table equals the netlist table; errors are
    // the differing bits; first error is the lowest differing index.
    function automatic exp_t model(input logic [15:0] net, input logic [15:0] e,
                                   input int unsigned done_cyc);
        exp_t r;
        r.tt    = net;
        r.err   = 5'd0;
        r.first = 4'd0;
        for (int m = 0; m < TTW; m++) begin
            if (net[m] != e[m]) begin
                if (r.err == 5'd0) r.first = m[3:0];
                r.err = r.err + 5'd1;
            end
        end
        r.match = (net == e);
        r.cyc   = done_cyc;
        return r;
    endfunction

    function automatic int qsz(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int s, input exp_t e);
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (done_v[s] === 1'b1) begin
                if (qsz(s) == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done dut%0d: got done_o=1, want 0 (nothing pending, cyc=%0d)",
                             s, cyc);
                end else begin
                    exp_t e;
                    if (s == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("dut%0d_done_cycle", s), cyc, e.cyc);
                    chk($sformatf("dut%0d_tt", s), {16'd0, tt_v[s]}, {16'd0, e.tt});
                    chk($sformatf("dut%0d_match", s), {31'd0, match_v[s]}, {31'd0, e.match});
                    chk($sformatf("dut%0d_err_cnt", s), {27'd0, err_v[s]}, {27'd0, e.err});
                    chk($sformatf("dut%0d_first_err", s), {28'd0, first_v[s]}, {28'd0, e.first});
                    chk($sformatf("dut%0d_busy_in_done", s), {31'd0, busy_v[s]}, 32'd0);
                    chk($sformatf("dut%0d_x_in_done", s), {28'd0, x_v[s]}, 32'd0);
                end
            end
        end
    end

    // Launch one sweep; returns the edge index at which start was accepted.
    task automatic start_sweep(input int s, input logic [15:0] net, input logic [15:0] e,
                               input bit hold, output int unsigned e_edge);
        @(negedge clk);
        net_v[s]   = net;
        expin_v[s] = e;
        start_v[s] = 1'b1;
        e_edge     = cyc + 1;
        push_exp(s, model(net, e, e_edge + TTW + lat_of(s)));
        @(negedge clk);
        if (!hold) start_v[s] = 1'b0;
        // The expected table is latched at start; later changes must not matter.
        expin_v[s] = 16'($urandom);
        chk($sformatf("dut%0d_busy_rise", s), {31'd0, busy_v[s]}, 32'd1);
        chk($sformatf("dut%0d_x_first", s), {28'd0, x_v[s]}, 32'd0);
    endtask

    // Bounded wait for all pending results, then an idle gap to expose stray pulses.
    task automatic wait_done(input int s);
        int n;
        n = 0;
        while (qsz(s) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (qsz(s) != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout dut%0d: got %0d results pending, want 0", s, qsz(s));
            if (s == 0) q0.delete();
            else        q1.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic chk_all_zero(input int s, input string tag);
        chk($sformatf("%s_x", tag), {28'd0, x_v[s]}, 32'd0);
        chk($sformatf("%s_busy", tag), {31'd0, busy_v[s]}, 32'd0);
        chk($sformatf("%s_done", tag), {31'd0, done_v[s]}, 32'd0);
        chk($sformatf("%s_tt", tag), {16'd0, tt_v[s]}, 32'd0);
        chk($sformatf("%s_match", tag), {31'd0, match_v[s]}, 32'd0);
        chk($sformatf("%s_err", tag), {27'd0, err_v[s]}, 32'd0);
        chk($sformatf("%s_first", tag), {28'd0, first_v[s]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned e_edge;
        int          s;
        logic [15:0] net;
        logic [15:0] e;
        logic [15:0] one16;

        n_cmp   = 0;
        n_err   = 0;
        one16   = 16'h0001;
        rst_n   = 1'b0;
        start_v = 2'b00;
        expin_v = '0;
        net_v   = '0;
        repeat (3) @(negedge clk);
        chk_all_zero(0, "reset0");
        chk_all_zero(1, "reset1");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // AND of all inputs, combinational.
        start_sweep(0, 16'h8000, 16'h8000, 1'b0, e_edge);
        wait_done(0);

        // XOR of all inputs through two register stages.
        start_sweep(1, 16'h6996, 16'h6996, 1'b0, e_edge);
        wait_done(1);

        // y = x0 against a table with one extra bit at minterm 0.
        start_sweep(0, 16'hAAAA, 16'hAAAB, 1'b0, e_edge);
        wait_done(0);
        start_sweep(1, 16'hAAAA, 16'hAAAB, 1'b0, e_edge);
        wait_done(1);

        // y stuck at 0: eight misses, lowest at minterm 4.
        start_sweep(0, 16'h0000, 16'hF0F0, 1'b0, e_edge);
        wait_done(0);

        // Every minterm wrong: count reaches its maximum of 16.
        start_sweep(1, 16'hFFFF, 16'h0000, 1'b0, e_edge);
        wait_done(1);

        // Start pulsed again mid-sweep must be ignored.
        for (s = 0; s < 2; s++) begin
            start_sweep(s, 16'h1234, 16'h1234, 1'b0, e_edge);
            while (cyc < e_edge + 5) @(negedge clk);
            start_v[s] = 1'b1;
            @(negedge clk);
            start_v[s] = 1'b0;
            wait_done(s);
        end

        // Start held high: the next sweep is accepted in the first idle cycle.
        for (s = 0; s < 2; s++) begin
            net = 16'h5A0F;
            e   = 16'h5A1F;
            start_sweep(s, net, e, 1'b1, e_edge);
            expin_v[s] = e;
            push_exp(s, model(net, e, e_edge + 2 * (TTW + lat_of(s)) + 2));
            while (cyc < e_edge + TTW + lat_of(s) + 2) @(negedge clk);
            start_v[s] = 1'b0;
            wait_done(s);
        end

        // Reset in the middle of a sweep: everything clears, no done pulse.
        start_sweep(0, 16'hFFFF, 16'h0000, 1'b0, e_edge);
        while (cyc < e_edge + 7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero(0, "midreset");
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        start_sweep(0, 16'h8000, 16'h8000, 1'b0, e_edge);
        wait_done(0);

        // Randomized tables on both instances.
        for (int i = 0; i < 12; i++) begin
            s   = int'($urandom_range(0, 1));
            net = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       e = net;
                1:       e = net ^ (one16 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            start_sweep(s, net, e, 1'b0, e_edge);
            wait_done(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tt_sweep_capture

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Exhaustive truth-table sweep stage for a 4-input single-output MIG netlist under test. On `start_i` it drives every input minterm in ascending order onto the netlist inputs and samples the netlist output after a fixed pipeline latency. It assembles the captured 16-bit truth table and checks it bit-for-bit against an expected table. It sits directly around the synthesized network: upstream it feeds `x0..x3`, downstream it consumes `y0`.

## Interface
- `NIN`, 4: number of netlist inputs; `TTW = 2**NIN` is the truth-table width.
- `LAT`, 0: cycles between driving `x_o` and a valid `y_i`; legal range 0..4. 0 means a purely combinational netlist.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: sweep request; sampled only in IDLE.
- `expect_tt_i` in TTW: expected truth table, bit m = f(minterm m); latched on accepted start.
- `x_o` in/out: out NIN: netlist inputs; `x_o[i]` drives `x_i` (minterm index LSB = `x0`).
- `y_i` in 1: netlist output `y0`.
- `busy_o` out 1: sweep or drain in progress.
- `done_o` out 1: one-cycle pulse; results valid from this cycle until the next accepted start.
- `tt_o` out TTW: captured truth table.
- `match_o` out 1: 1 iff `tt_o == expected`; meaningful only when results are valid.
- `err_cnt_o` out NIN+1: number of mismatching minterms (0..16).
- `first_err_o` out NIN: lowest mismatching minterm index; 0 when there is no mismatch.

## Operation
- FSM states:
  - IDLE: wait. `start_i` = 1 → SWEEP. On entry to SWEEP, latch `expect_tt_i` and clear `tt_o`, `err_cnt_o`, `first_err_o` and `match_o`.
  - SWEEP: `x_o` = k on the k-th cycle, k = 0..TTW-1. After minterm TTW-1 → DRAIN if `LAT` > 0, otherwise → DONE.
  - DRAIN: hold `x_o` at TTW-1 for `LAT` cycles, then → DONE.
  - DONE: one cycle. `done_o` = 1 and `match_o` = (`err_cnt_o` == 0). Then unconditionally → IDLE.
- Latency tracking: a delay line of depth `LAT` carries a valid bit and the NIN-bit minterm tag alongside each driven minterm.
- When a tagged sample emerges with tag m:
  - write `y_i` into `tt_o[m]`;
  - on mismatch with `expect[m]`, increment `err_cnt_o`;
  - if this is the first mismatch, set `first_err_o` = m.
- Because minterms arrive in ascending order, the first recorded error is always the lowest index.
- `err_cnt_o` saturation is unnecessary: its width holds 16.
- `start_i` is ignored in SWEEP, DRAIN and DONE. A held `start_i` restarts on the cycle after DONE.
- `x_o` returns to 0 in IDLE and DONE.
- Reset, including mid-sweep: state → IDLE and every output → 0 (`x_o`, `busy_o`, `done_o`, `tt_o`, `match_o`, `err_cnt_o`, `first_err_o`). Any in-flight samples are discarded and no `done_o` is emitted.

## Timing
- Start sampled at edge t: `busy_o` rises and `x_o` = 0 in cycle t+1.
- Minterm k is driven in cycle t+1+k.
- Its sample is taken at the edge ending cycle t+1+k+`LAT`.
- `done_o` is high in cycle t+1+TTW+`LAT`, i.e. t+17 for `LAT` = 0 and t+19 for `LAT` = 2.
- `busy_o` is high from t+1 through the cycle before `done_o`; it is low in the DONE cycle.
- Results (`tt_o`, `err_cnt_o`, `first_err_o`) update incrementally during the sweep. Consumers use them only from `done_o` onward.
- Earliest next start is sampled at the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.

## Structure
- Package `tt_sweep_pkg` holds:
  - the `NIN`/`TTW` defaults and `LAT_MAX` = 4;
  - the state enum (IDLE, SWEEP, DRAIN, DONE);
  - the minterm index typedef.
- One sub-module, `tt_lat_pipe`: a parameterized valid+tag delay line of depth `LAT`. At depth 0 it is a pass-through.
- Top level contains the FSM, minterm counter, capture register and compare/error logic.

## Test plan
- `y_i` = `x0&x1&x2&x3`, `expect` 16'h8000, `LAT` = 0, start at t → `done_o` at t+17, `tt_o` = 16'h8000, `match_o` = 1, `err_cnt_o` = 0.
- `y_i` = XOR of all inputs through 2 register stages, `LAT` = 2, `expect` 16'h6996 → `done_o` at t+19, `tt_o` = 16'h6996, `match_o` = 1.
- `y_i` = `x0`, `expect` 16'hAAAB → `tt_o` = 16'hAAAA, `match_o` = 0, `err_cnt_o` = 1, `first_err_o` = 0.
- `y_i` tied to 0, `expect` 16'hF0F0 → `err_cnt_o` = 8, `first_err_o` = 4, `tt_o` = 0.
- `start_i` pulsed again during SWEEP → ignored, single `done_o`; `start_i` held high → second sweep begins the cycle after DONE.
- `rst_n` low in cycle t+8 → all outputs 0 immediately, no `done_o`; a new start after release gives a full, correct result.
